ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Parametrised AHB-Lite SRAM slave that replaces the fixed 8-bit, 256-byte memory controller on the bus fabric. It supports configurable data width, memory depth and wait states, and honours HSIZE byte lanes. It returns a proper two-cycle ERROR response for illegal accesses and takes every beat address from HADDR, so any burst type, including one interrupted by BUSY, is handled without internal address regeneration. The block sits behind the decoder as one HSEL target and instantiates one byte-enabled storage bank.

## Interface
- ADDR_WIDTH, 32: HADDR width.
- DATA_WIDTH, 32: bus width; legal values are 32 and 64.
- MEM_BYTES, 1024: storage size in bytes; must be a power of two and at least DATA_WIDTH/8.
- WAIT_STATES, 0: added data-phase cycles per OKAY transfer; legal range 0–15.

Ports:
- HCLK, in, 1: bus clock. One clock domain, rising edge.
- HRESETn, in, 1: asynchronous, active-low reset.
- HSEL, in, 1: slave select.
- HADDR, in, ADDR_WIDTH: byte address.
- HTRANS, in, Trans_t: IDLE, BUSY, NONSEQ or SEQ.
- HWRITE, in, 1: 1 = write.
- HSIZE, in, 3: transfer size code.
- HBURST, in, BType_t: accepted and ignored.
- HPROT, in, 4: accepted and ignored.
- HMASTLOCK, in, 1: accepted and ignored.
- HREADY, in, 1: bus-wide ready.
- HWDATA, in, DATA_WIDTH: write data, sampled in the data phase.
- HREADYOUT, out, 1: slave ready.
- HRESP, out, Response_t: OKAY or ERROR.
- HRDATA, out, DATA_WIDTH: read data.

## Operation
- **Address-phase accept:** a transfer is accepted when HSEL & HREADY & (HTRANS==NONSEQ or SEQ) at a rising edge.
  - On accept, the block registers the address, HWRITE, HSIZE and byte enables.
  - SEQ is handled exactly like NONSEQ.
  - IDLE, BUSY, or HSEL low gets a zero-wait OKAY with no storage access.
- **Legality check** (at accept). A transfer is illegal if any of these hold:
  - HADDR ≥ MEM_BYTES (upper bits non-zero);
  - 2^HSIZE > DATA_WIDTH/8;
  - HADDR is not aligned to 2^HSIZE.
- **Byte enables:** little-endian. Lane i is enabled when i lies in [HADDR mod (DATA_WIDTH/8), + 2^HSIZE).
- **Data-phase state machine:** states are IDLE, DATA, ERR1, ERR2.
  - IDLE → DATA on a legal accept.
  - IDLE → ERR1 on an illegal accept.
  - DATA: a down-counter is loaded with WAIT_STATES at accept. HREADYOUT=0 while the count is non-zero, decrementing each cycle. When the count is 0, HREADYOUT=1 and HRESP=OKAY; the transfer completes.
  - ERR1: HREADYOUT=0, HRESP=ERROR. ERR1 → ERR2 unconditionally.
  - ERR2: HREADYOUT=1, HRESP=ERROR. No storage access occurs.
  - From the completing cycle of DATA or ERR2, the next state is DATA, ERR1 or IDLE according to the address phase accepted in that same cycle (pipelined back-to-back).
- **Write:** enabled lanes of HWDATA are committed at the rising edge that ends the completing DATA cycle. Disabled lanes are unchanged.
- **Read:** HRDATA carries the full storage word at the registered word address during the completing DATA cycle. The bus master selects the lanes it needs.
- **HRDATA value outside read completion:** HRDATA = 0 in every cycle that is not a read-completion cycle. The bus is never tri-stated.
- **Read after write:** a read immediately following a write to the same address returns the new data. The write commits on the same edge that starts the read's data phase, so no forwarding path is needed.
- **Reset:** on HRESETn assertion:
  - state = IDLE, HREADYOUT = 1, HRESP = OKAY, HRDATA = 0, counter = 0;
  - any pending write is dropped;
  - storage contents are not reset.

## Timing
- **Address phase:** cycle T.
- **OKAY transfer:**
  - HREADYOUT=0 in cycles T+1 .. T+WAIT_STATES;
  - HREADYOUT=1 in cycle T+1+WAIT_STATES;
  - latency is 1+WAIT_STATES cycles.
- **ERROR transfer:**
  - T+1 gives ERROR with HREADYOUT=0;
  - T+2 gives ERROR with HREADYOUT=1;
  - WAIT_STATES does not apply.
- **Stalled address phase:** a new address phase presented while HREADY=0 is not sampled. The master holds it and it is accepted in the completing cycle.
- **Outputs:** HREADYOUT and HRESP are driven directly from the state and counter (registered-state decode). No combinational path exists from HADDR to HREADYOUT.

## Structure
- **Shared package `Definitions`** holds:
  - Trans_t, BType_t, Response_t;
  - a new enum SlvState_t {S_IDLE, S_DATA, S_ERR1, S_ERR2};
  - HSIZE code constants.
- **Sub-module `sram_bank`**, parameters DEPTH_WORDS and DATA_WIDTH:
  - ports: clk, wr_en, byte_en[DATA_WIDTH/8], waddr, wdata, raddr, rdata;
  - combinational read, synchronous byte-masked write.
- **Top level** contains the address/control registers, the legality check, the wait counter and the FSM.

## Test plan
1. **Zero-wait word write then read** (WAIT_STATES=0): write 0xDEADBEEF to 0x010, then read 0x010 back-to-back. Required: HREADYOUT stays 1 throughout and the read returns 0xDEADBEEF.
2. **Byte and halfword lanes:** fill 0x020 with 0x00000000, write byte 0xAA to 0x021, then write halfword 0x5566 to 0x022. Required: reading word 0x020 returns 0x5566AA00.
3. **Wait states** (WAIT_STATES=2): read 0x040. Required: HREADYOUT is 0,0,1 across the data-phase cycles, and HRDATA equals the stored value only in the third cycle.
4. **Error cases:**
   - out-of-range write to 0x400 (MEM_BYTES=1024);
   - misaligned word read at 0x003.
   
   Required for each: ERROR with HREADYOUT=0, then ERROR with HREADYOUT=1. Storage is unchanged and the next OKAY transfer completes normally.
5. **INCR4 with BUSY:** INCR4 write from 0x080 with a BUSY inserted after beat 2. Required: the BUSY cycle gets a zero-wait OKAY and 0x080–0x08C hold the four data words.
6. **Reset mid-transfer** (WAIT_STATES=3): assert HRESETn during the wait cycles of a write to 0x100. Required: outputs go immediately to HREADYOUT=1, OKAY, HRDATA=0, and 0x100 is not modified.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite types and constants for the SRAM slave and its bus interface.
// Also holds the little-endian byte-lane mask helper used at address-phase accept.
package Definitions;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } Trans_t;

    typedef enum logic [2:0] {
        SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16
    } BType_t;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } Response_t;

    typedef enum logic [1:0] {
        S_IDLE, S_DATA, S_ERR1, S_ERR2
    } SlvState_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // 2^hsize consecutive lanes starting at offset, for buses up to 8 lanes.
    function automatic logic [7:0] lane_mask(input logic [2:0] offset, input logic [2:0] hsize);
        logic [15:0] span;
        span = (16'd1 << (16'd1 << hsize)) - 16'd1;
        return 8'(span << offset);
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus signals for one HSEL target; master drives the request, slave the response.
interface ahb_sram_slave_if
    import Definitions::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    Trans_t                HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    BType_t                HBURST;
    logic [3:0]            HPROT;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic                  HREADYOUT;
    Response_t             HRESP;
    logic [DATA_WIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HREADY, HWDATA,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave_sram_bank.sv
// Byte-enabled storage bank: combinational read, synchronous byte-masked write.
module sram_bank #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_WIDTH  = 32,
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1,
    localparam int NB = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [NB-1:0]         byte_en,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (byte_en[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: legality check at accept, wait-state counter and data-phase FSM
// in front of one byte-enabled storage bank; every beat address comes straight from HADDR.
module ahb_sram_slave
    import Definitions::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_sram_slave_if.slave bus
);
    localparam int NBYTES      = DATA_WIDTH / 8;
    localparam int LANE_W      = $clog2(NBYTES);
    localparam int MEM_AW      = $clog2(MEM_BYTES);
    localparam int DEPTH_WORDS = MEM_BYTES / NBYTES;
    localparam int WADDR_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    SlvState_t             state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q;
    logic [WADDR_W-1:0]    waddr_q;
    logic [NBYTES-1:0]     be_q;

    logic                  accept, take, legal, ready_int, complete_ok, wr_en;
    logic                  out_of_range, size_bad, misaligned;
    logic [7:0]            align_mask, mask8;
    logic [NBYTES-1:0]     be_d;
    logic [WADDR_W-1:0]    waddr_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_ok;

    assign accept = bus.HSEL && bus.HREADY && (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ);

    assign out_of_range = |(bus.HADDR >> MEM_AW);
    assign size_bad     = int'(bus.HSIZE) > LANE_W;
    assign align_mask   = 8'((16'd1 << bus.HSIZE) - 16'd1);
    assign misaligned   = |(bus.HADDR[7:0] & align_mask);
    assign legal        = !(out_of_range || size_bad || misaligned);

    assign mask8   = lane_mask(3'(bus.HADDR[LANE_W-1:0]), bus.HSIZE);
    assign be_d    = mask8[NBYTES-1:0];
    assign waddr_d = WADDR_W'(bus.HADDR >> LANE_W);

    // Ready is a pure decode of registered state, so HADDR never reaches HREADYOUT.
    assign ready_int   = !((state_q == S_DATA && cnt_q != 4'd0) || state_q == S_ERR1);
    assign complete_ok = (state_q == S_DATA) && (cnt_q == 4'd0);
    assign take        = accept && ready_int;
    assign wr_en       = complete_ok && write_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_ERR1) state_d = S_ERR2;
        if (state_q == S_DATA && cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        // Any ready cycle ends the current data phase; the next one follows the address phase.
        if (ready_int) begin
            if (take) begin
                state_d = legal ? S_DATA : S_ERR1;
                cnt_d   = legal ? 4'(WAIT_STATES) : 4'd0;
            end else begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (take) begin
            write_q <= bus.HWRITE;
            waddr_q <= waddr_d;
            be_q    <= be_d;
        end
    end

    sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk    (HCLK),
        .wr_en  (wr_en),
        .byte_en(be_q),
        .waddr  (waddr_q),
        .wdata  (bus.HWDATA),
        .raddr  (waddr_q),
        .rdata  (rdata)
    );

    assign bus.HREADYOUT = ready_int;
    assign bus.HRESP     = (state_q == S_ERR1 || state_q == S_ERR2) ? ERROR : OKAY;
    assign bus.HRDATA    = (complete_ok && !write_q) ? rdata : '0;

    assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, mask8};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances with 0, 2 and 3 wait states,
// each a single-slave bus where HREADY loops back from HREADYOUT.
module tb_ahb_sram_slave;
    import Definitions::*;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rst_n [3];
    logic        sel   [3];
    logic [31:0] addr  [3];
    Trans_t      trans [3];
    logic        wr    [3];
    logic [2:0]  size  [3];
    BType_t      burst [3];
    logic [31:0] wdata [3];
    logic        rdy   [3];
    Response_t   resp  [3];
    logic [31:0] rdata [3];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();
        assign bus_if.HSEL      = sel[g];
        assign bus_if.HADDR     = addr[g];
        assign bus_if.HTRANS    = trans[g];
        assign bus_if.HWRITE    = wr[g];
        assign bus_if.HSIZE     = size[g];
        assign bus_if.HBURST    = burst[g];
        assign bus_if.HPROT     = 4'b0011;
        assign bus_if.HMASTLOCK = 1'b0;
        assign bus_if.HREADY    = bus_if.HREADYOUT;
        assign bus_if.HWDATA    = wdata[g];
        assign rdy[g]   = bus_if.HREADYOUT;
        assign resp[g]  = bus_if.HRESP;
        assign rdata[g] = bus_if.HRDATA;
        ahb_sram_slave #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(1024), .WAIT_STATES(WS)
        ) u_dut (
            .HCLK   (HCLK),
            .HRESETn(rst_n[g]),
            .bus    (bus_if)
        );
    end

    task automatic tick();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic drive(input int k, input Trans_t t, input logic w, input logic [2:0] s,
                         input logic [31:0] a);
        sel[k] = 1'b1; trans[k] = t; wr[k] = w; size[k] = s; addr[k] = a;
    endtask

    task automatic idle_bus(input int k);
        sel[k] = 1'b0; trans[k] = IDLE; wr[k] = 1'b0; size[k] = HSIZE_WORD; addr[k] = 32'h0;
    endtask

    task automatic single_write(input int k, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        drive(k, NONSEQ, 1'b1, HSIZE_WORD, a);
        tick();
        idle_bus(k);
        wdata[k] = d;
        while (rdy[k] !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL write_timeout: HREADYOUT=%b required 1", rdy[k]);
        end
        tick();
    endtask

    task automatic single_read(input int k, input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        drive(k, NONSEQ, 1'b0, HSIZE_WORD, a);
        tick();
        idle_bus(k);
        while (rdy[k] !== 1'b1 && n < 20) begin tick(); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL read_timeout: HREADYOUT=%b required 1", rdy[k]);
        end
        d = rdata[k];
        tick();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; idle_bus(k); burst[k] = SINGLE; wdata[k] = 32'h0;
        end
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1'b1 || resp[k] !== OKAY || rdata[k] !== 32'h0) begin
                errors++;
                $display("FAIL reset_state[%0d]: rdy=%b resp=%b rdata=%h required 1 0 00000000",
                         k, rdy[k], resp[k], rdata[k]);
            end
        end
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
        tick();
    endtask

    task automatic test_zero_wait();
        drive(0, NONSEQ, 1'b1, HSIZE_WORD, 32'h010);
        tick();
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL zw_write_ready: got %b required 1", rdy[0]); end
        wdata[0] = 32'hDEADBEEF;
        drive(0, NONSEQ, 1'b0, HSIZE_WORD, 32'h010);
        tick();
        checks++;
        if (rdy[0] !== 1'b1 || resp[0] !== OKAY) begin
            errors++; $display("FAIL zw_read_ready: rdy=%b resp=%b required 1 0", rdy[0], resp[0]);
        end
        checks++;
        if (rdata[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL zw_read_data: got %h required deadbeef", rdata[0]);
        end
        idle_bus(0);
        tick();
        checks++;
        if (rdata[0] !== 32'h0) begin errors++; $display("FAIL zw_rdata_idle: got %h required 0", rdata[0]); end
    endtask

    task automatic test_lanes();
        drive(0, NONSEQ, 1'b1, HSIZE_WORD, 32'h020);
        tick();
        wdata[0] = 32'h0;
        drive(0, NONSEQ, 1'b1, HSIZE_BYTE, 32'h021);
        tick();
        wdata[0] = 32'h1122AA33;
        drive(0, NONSEQ, 1'b1, HSIZE_HALF, 32'h022);
        tick();
        wdata[0] = 32'h55667788;
        drive(0, NONSEQ, 1'b0, HSIZE_WORD, 32'h020);
        tick();
        checks++;
        if (rdata[0] !== 32'h5566AA00) begin
            errors++; $display("FAIL lanes_word: got %h required 5566aa00", rdata[0]);
        end
        idle_bus(0);
        tick();
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_d;
        single_write(1, 32'h040, 32'hCAFEF00D);
        drive(1, NONSEQ, 1'b0, HSIZE_WORD, 32'h040);
        tick();
        idle_bus(1);
        for (int i = 0; i < 3; i++) begin
            exp_d = (i == 2) ? 32'hCAFEF00D : 32'h0;
            checks++;
            if (rdy[1] !== (i == 2)) begin
                errors++; $display("FAIL ws_ready[%0d]: got %b required %b", i, rdy[1], (i == 2));
            end
            checks++;
            if (rdata[1] !== exp_d) begin
                errors++; $display("FAIL ws_rdata[%0d]: got %h required %h", i, rdata[1], exp_d);
            end
            tick();
        end
        checks++;
        if (rdata[1] !== 32'h0) begin errors++; $display("FAIL ws_rdata_after: got %h required 0", rdata[1]); end
    endtask

    task automatic test_errors();
        drive(0, NONSEQ, 1'b1, HSIZE_WORD, 32'h000);
        tick();
        wdata[0] = 32'h13579BDF;
        drive(0, NONSEQ, 1'b1, HSIZE_WORD, 32'h400);
        tick();
        checks++;
        if (rdy[0] !== 1'b0 || resp[0] !== ERROR) begin
            errors++; $display("FAIL oor_err1: rdy=%b resp=%b required 0 1", rdy[0], resp[0]);
        end
        wdata[0] = 32'hFFFFFFFF;
        idle_bus(0);
        tick();
        checks++;
        if (rdy[0] !== 1'b1 || resp[0] !== ERROR) begin
            errors++; $display("FAIL oor_err2: rdy=%b resp=%b required 1 1", rdy[0], resp[0]);
        end
        drive(0, NONSEQ, 1'b0, HSIZE_WORD, 32'h003);
        tick();
        idle_bus(0);
        checks++;
        if (rdy[0] !== 1'b0 || resp[0] !== ERROR || rdata[0] !== 32'h0) begin
            errors++; $display("FAIL mis_err1: rdy=%b resp=%b rdata=%h required 0 1 0", rdy[0], resp[0], rdata[0]);
        end
        tick();
        checks++;
        if (rdy[0] !== 1'b1 || resp[0] !== ERROR || rdata[0] !== 32'h0) begin
            errors++; $display("FAIL mis_err2: rdy=%b resp=%b rdata=%h required 1 1 0", rdy[0], resp[0], rdata[0]);
        end
        drive(0, NONSEQ, 1'b0, HSIZE_WORD, 32'h000);
        tick();
        checks++;
        if (rdy[0] !== 1'b1 || resp[0] !== OKAY || rdata[0] !== 32'h13579BDF) begin
            errors++; $display("FAIL err_recover: rdy=%b resp=%b rdata=%h required 1 0 13579bdf",
                               rdy[0], resp[0], rdata[0]);
        end
        idle_bus(0);
        tick();
    endtask

    task automatic test_busy_burst();
        logic [31:0] beat [4];
        beat[0] = 32'hA0A00001; beat[1] = 32'hB1B10002; beat[2] = 32'hC2C20003; beat[3] = 32'hD3D30004;
        burst[0] = INCR4;
        drive(0, NONSEQ, 1'b1, HSIZE_WORD, 32'h080);
        tick();
        wdata[0] = beat[0];
        drive(0, SEQ, 1'b1, HSIZE_WORD, 32'h084);
        tick();
        wdata[0] = beat[1];
        drive(0, BUSY, 1'b1, HSIZE_WORD, 32'h088);
        tick();
        checks++;
        if (rdy[0] !== 1'b1 || resp[0] !== OKAY) begin
            errors++; $display("FAIL busy_okay: rdy=%b resp=%b required 1 0", rdy[0], resp[0]);
        end
        drive(0, SEQ, 1'b1, HSIZE_WORD, 32'h088);
        tick();
        wdata[0] = beat[2];
        drive(0, SEQ, 1'b1, HSIZE_WORD, 32'h08C);
        tick();
        wdata[0] = beat[3];
        idle_bus(0);
        burst[0] = SINGLE;
        tick();
        drive(0, NONSEQ, 1'b0, HSIZE_WORD, 32'h080);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(0, NONSEQ, 1'b0, HSIZE_WORD, 32'h080 + 32'(4 * (i + 1)));
            else idle_bus(0);
            checks++;
            if (rdata[0] !== beat[i]) begin
                errors++; $display("FAIL burst_beat[%0d]: got %h required %h", i, rdata[0], beat[i]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        single_write(2, 32'h100, 32'h0BADF00D);
        drive(2, NONSEQ, 1'b1, HSIZE_WORD, 32'h100);
        tick();
        wdata[2] = 32'hFFFFFFFF;
        idle_bus(2);
        checks++;
        if (rdy[2] !== 1'b0) begin errors++; $display("FAIL rst_wait1: got %b required 0", rdy[2]); end
        tick();
        checks++;
        if (rdy[2] !== 1'b0) begin errors++; $display("FAIL rst_wait2: got %b required 0", rdy[2]); end
        rst_n[2] = 1'b0;
        #1;
        checks++;
        if (rdy[2] !== 1'b1 || resp[2] !== OKAY || rdata[2] !== 32'h0) begin
            errors++; $display("FAIL rst_async: rdy=%b resp=%b rdata=%h required 1 0 0", rdy[2], resp[2], rdata[2]);
        end
        tick(); tick();
        rst_n[2] = 1'b1;
        tick();
        single_read(2, 32'h100, d);
        checks++;
        if (d !== 32'h0BADF00D) begin errors++; $display("FAIL rst_storage: got %h required 0badf00d", d); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_lanes();
        test_wait_states();
        test_errors();
        test_busy_burst();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
